// File: rtl/rgb_ctrl_pkg.sv
// ============================================================================
// rgb_ctrl_pkg : shared types, widths and step helper for the RGB fade block
// Revision     : 1.0
// ============================================================================
`default_nettype none

package rgb_ctrl_pkg;

  localparam int NUM_CH  = 3;
  localparam int LEVEL_W = 8;

  typedef logic [1:0]         chan_t;
  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_FADING = 1'b1
  } state_t;

  // One unit toward the target; saturates naturally since it never passes it.
  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    level_t res;
    res = cur;
    if (cur < tgt) begin
      res = cur + level_t'(1);
    end else if (cur > tgt) begin
      res = cur - level_t'(1);
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_fade_channel.sv
// ============================================================================
// rgb_fade_channel : per-channel target/current pair with step and jump
// Revision         : 1.0
// ============================================================================
`default_nettype none

module rgb_fade_channel
  import rgb_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_LEVEL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic [7:0] wr_level_i,
  input  logic       step_i,
  input  logic       jump_i,
  output logic [7:0] target_o,
  output logic [7:0] level_o
);

  level_t target_q;
  level_t current_q;
  level_t current_d;

  // Step and jump both look at the registered target, so a new target is
  // seen by current one cycle after it is written.
  always_comb begin
    current_d = current_q;
    if (jump_i) begin
      current_d = target_q;
    end else if (step_i) begin
      current_d = step_toward(current_q, target_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= RESET_LEVEL;
      current_q <= RESET_LEVEL;
    end else begin
      if (wr_en_i) begin
        target_q <= wr_level_i;
      end
      current_q <= current_d;
    end
  end

  assign target_o = target_q;
  assign level_o  = current_q;

endmodule

`default_nettype wire

// File: rtl/rgb_fade_ctrl.sv
// ============================================================================
// rgb_fade_ctrl : three-channel LED level controller with timed fading
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rgb_fade_ctrl
  import rgb_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1000,
  parameter logic [7:0]  RESET_LEVEL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_valid,
  input  logic [1:0] enc_chan,
  input  logic [7:0] enc_level,
  input  logic       host_valid,
  input  logic [1:0] host_chan,
  input  logic [7:0] host_level,
  output logic       host_ready,
  input  logic       fade_en,
  output logic [7:0] level0,
  output logic [7:0] level1,
  output logic [7:0] level2,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic        hold_valid_q;
  chan_t       hold_chan_q;
  level_t      hold_level_q;
  state_t      state_q;
  logic [15:0] tick_cnt_q;
  logic        done_q;

  level_t            w_level    [NUM_CH];
  level_t            w_target   [NUM_CH];
  level_t            w_wr_level [NUM_CH];
  logic [NUM_CH-1:0] w_wr_en;
  logic [NUM_CH-1:0] w_mismatch;
  logic [NUM_CH-1:0] w_settles;
  logic              w_accept;
  logic              w_tick;
  logic              w_step;
  logic              w_jump;

  // Ready is gated by reset directly so it reads 1 in the very first cycle
  // after reset is released.
  assign host_ready = ~reset & ~hold_valid_q;
  assign w_accept   = host_valid & host_ready;
  assign w_tick     = (state_q == ST_FADING) && (tick_cnt_q == TICK_LAST);
  assign w_step     = w_tick & fade_en;
  assign w_jump     = ~fade_en;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_host_hit;
      logic w_enc_hit;

      assign w_host_hit    = hold_valid_q && (hold_chan_q == chan_t'(i));
      assign w_enc_hit     = enc_valid && (enc_chan == chan_t'(i));
      assign w_wr_en[i]    = w_host_hit | w_enc_hit;
      assign w_wr_level[i] = w_host_hit ? hold_level_q : enc_level;
      assign w_mismatch[i] = (w_level[i] != w_target[i]);
      assign w_settles[i]  = (step_toward(w_level[i], w_target[i]) == w_target[i]);

      rgb_fade_channel #(
        .RESET_LEVEL (RESET_LEVEL)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (w_wr_en[i]),
        .wr_level_i (w_wr_level[i]),
        .step_i     (w_step),
        .jump_i     (w_jump),
        .target_o   (w_target[i]),
        .level_o    (w_level[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      done_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_chan_q  <= '0;
      hold_level_q <= '0;
    end else begin
      done_q       <= 1'b0;
      hold_valid_q <= w_accept;
      if (w_accept) begin
        hold_chan_q  <= host_chan;
        hold_level_q <= host_level;
      end
      case (state_q)
        ST_IDLE: begin
          tick_cnt_q <= '0;
          if (fade_en && (|w_mismatch)) begin
            state_q <= ST_FADING;
          end
        end
        ST_FADING: begin
          tick_cnt_q <= w_tick ? 16'd0 : tick_cnt_q + 16'd1;
          if (!fade_en) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
          end else if (!(|w_mismatch)) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
          end else if (w_tick && (&w_settles)) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign level0 = w_level[0];
  assign level1 = w_level[1];
  assign level2 = w_level[2];
  assign busy   = (state_q == ST_FADING);
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb_fade_ctrl.sv
// ============================================================================
// tb_rgb_fade_ctrl : directed and randomized checks against a cycle model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_rgb_fade_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enc_valid = 1'b0;
  logic [1:0] enc_chan = 2'd0;
  logic [7:0] enc_level = 8'd0;
  logic       host_valid = 1'b0;
  logic [1:0] host_chan = 2'd0;
  logic [7:0] host_level = 8'd0;
  logic       host_ready;
  logic       fade_en = 1'b0;
  logic [7:0] level0, level1, level2;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_tgt[3];
  int m_cur[3];
  bit m_hv;
  int m_hc, m_hl;
  bit m_busy, m_done;
  int m_age;

  int vals[8];
  int cycs[8];
  int nchg, ndone, dlvl;

  rgb_fade_ctrl #(
    .TICK_DIV    (TD),
    .RESET_LEVEL (8'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_valid  (enc_valid),
    .enc_chan   (enc_chan),
    .enc_level  (enc_level),
    .host_valid (host_valid),
    .host_chan  (host_chan),
    .host_level (host_level),
    .host_ready (host_ready),
    .fade_en    (fade_en),
    .level0     (level0),
    .level1     (level1),
    .level2     (level2),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  function automatic void model_update();
    int  n_tgt[3];
    bit  all_eq, accept, tick_now;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
      m_hv = 0; m_busy = 0; m_done = 0; m_age = 0;
      return;
    end
    for (int i = 0; i < 3; i++) n_tgt[i] = m_tgt[i];
    if (enc_valid && enc_chan != 2'd3) n_tgt[enc_chan] = enc_level;
    if (m_hv && m_hc != 3) n_tgt[m_hc] = m_hl;
    accept = host_valid && !m_hv;
    all_eq = 1;
    for (int i = 0; i < 3; i++) if (m_cur[i] != m_tgt[i]) all_eq = 0;
    m_done = 0;
    if (!fade_en) begin
      for (int i = 0; i < 3; i++) m_cur[i] = m_tgt[i];
      m_busy = 0;
    end else if (!m_busy) begin
      m_busy = !all_eq;
      m_age  = 0;
    end else if (all_eq) begin
      m_busy = 0;
    end else begin
      tick_now = (m_age % TD) == TD - 1;
      m_age++;
      if (tick_now) begin
        for (int i = 0; i < 3; i++) begin
          if (m_cur[i] < m_tgt[i]) m_cur[i]++;
          else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
        end
        all_eq = 1;
        for (int i = 0; i < 3; i++) if (m_cur[i] != m_tgt[i]) all_eq = 0;
        if (all_eq) begin m_busy = 0; m_done = 1; end
      end
    end
    m_hv = accept;
    if (accept) begin m_hc = host_chan; m_hl = host_level; end
    for (int i = 0; i < 3; i++) m_tgt[i] = n_tgt[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("level0", level0, m_cur[0]);
    chk("level1", level1, m_cur[1]);
    chk("level2", level2, m_cur[2]);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("host_ready", host_ready, (!reset && !m_hv));
  endtask

  task automatic host_write(input logic [1:0] ch, input logic [7:0] lv);
    host_valid = 1'b1; host_chan = ch; host_level = lv;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic run_fade(input int budget);
    logic [7:0] prev;
    prev = level0; nchg = 0; ndone = 0; dlvl = -1;
    for (int c = 0; c < budget && ndone == 0; c++) begin
      tick();
      if (level0 !== prev) begin
        if (nchg < 8) begin vals[nchg] = level0; cycs[nchg] = c; end
        nchg++;
        prev = level0;
      end
      if (done === 1'b1) begin ndone++; dlvl = level0; end
    end
    chk("fade_done_seen", ndone, 1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_level0", level0, 8'd0);
    chk("rst_ready", host_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", host_ready, 1'b1);

    // Jump mode: encoder write lands one cycle after the target update
    enc_valid = 1'b1; enc_chan = 2'd2; enc_level = 8'hFF;
    tick();
    enc_valid = 1'b0;
    tick();
    chk("enc_jump_l2", level2, 8'hFF);
    chk("enc_jump_busy", busy, 1'b0);
    tick();

    // Host commit beats encoder on the same channel
    host_write(2'd1, 8'h80);
    enc_valid = 1'b1; enc_chan = 2'd1; enc_level = 8'h10;
    tick();
    enc_valid = 1'b0;
    tick(); tick();
    chk("host_wins_l1", level1, 8'h80);

    // Channel 3 write is accepted but changes nothing
    host_write(2'd3, 8'h55);
    chk("ch3_ready_low", host_ready, 1'b0);
    tick();
    chk("ch3_ready_back", host_ready, 1'b1);
    tick();
    chk("ch3_l0", level0, 8'd0);
    chk("ch3_l1", level1, 8'h80);
    chk("ch3_l2", level2, 8'hFF);

    // Fade ch0 from 0 to 3
    reset = 1'b1; tick(); reset = 1'b0; tick();
    fade_en = 1'b1;
    host_write(2'd0, 8'd3);
    tick(); tick();
    chk("fade3_busy", busy, 1'b1);
    run_fade(60);
    chk("fade3_nchg", nchg, 3);
    chk("fade3_v0", vals[0], 1);
    chk("fade3_v1", vals[1], 2);
    chk("fade3_v2", vals[2], 3);
    chk("fade3_gap1", cycs[1] - cycs[0], TD);
    chk("fade3_gap2", cycs[2] - cycs[1], TD);
    chk("fade3_done_lvl", dlvl, 3);
    tick(); tick();

    // Retarget mid-fade at level 5 from a fade toward 10
    host_write(2'd0, 8'd10);
    for (int c = 0; c < 80 && level0 !== 8'd5; c++) tick();
    chk("retgt_reach5", level0, 8'd5);
    host_write(2'd0, 8'd2);
    run_fade(60);
    chk("retgt_nchg", nchg, 3);
    chk("retgt_v0", vals[0], 4);
    chk("retgt_v1", vals[1], 3);
    chk("retgt_v2", vals[2], 2);
    chk("retgt_done_lvl", dlvl, 2);
    tick();

    // Reset mid-fade with the holding register full
    host_write(2'd0, 8'd200);
    for (int c = 0; c < 10; c++) tick();
    host_write(2'd1, 8'h33);
    reset = 1'b1;
    tick();
    chk("midrst_l0", level0, 8'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", host_ready, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_ready_after", host_ready, 1'b1);
    tick(); tick();
    chk("midrst_l1_dropped", level1, 8'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      enc_valid  = ($urandom_range(0, 3) == 0);
      enc_chan   = 2'($urandom_range(0, 3));
      enc_level  = 8'($urandom_range(0, 11));
      host_valid = ($urandom_range(0, 2) == 0);
      host_chan  = 2'($urandom_range(0, 3));
      host_level = 8'($urandom_range(0, 11));
      if ($urandom_range(0, 19) == 0) fade_en = ~fade_en;
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; enc_valid = 1'b0; host_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rgb_fade_ctrl.md
RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clock cycles per fade step; legal range 2..65535.
REQ-002 SHALL have parameter RESET_LEVEL, default 8'd0: level loaded into every target and current register at reset.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port enc_valid, input, 1: encoder-side level update strobe, no handshake.
REQ-006 SHALL have port enc_chan, input, 2: encoder update channel index, 0..2.
REQ-007 SHALL have port enc_level, input, 8: encoder update target level.
REQ-008 SHALL have port host_valid, input, 1: host write request.
REQ-009 SHALL have port host_chan, input, 2: host write channel index.
REQ-010 SHALL have port host_level, input, 8: host write target level.
REQ-011 SHALL have port host_ready, output, 1: host holding register empty.
REQ-012 SHALL have port fade_en, input, 1: 1 = ramp toward targets; 0 = jump to targets.
REQ-013 SHALL have port level0, output, 8: current level, channel 0 (PWM duty).
REQ-014 SHALL have port level1, output, 8: current level, channel 1.
REQ-015 SHALL have port level2, output, 8: current level, channel 2.
REQ-016 SHALL have port busy, output, 1: state is FADING.
REQ-017 SHALL have port done, output, 1: one-cycle pulse on fade completion.

Function
REQ-018 SHALL hold one 8-bit target and one 8-bit current register per channel; levelN equals current N.
REQ-019 SHALL accept a host write when host_valid and host_ready are both 1, capture it into a 1-entry holding register, and drive host_ready 0 for exactly the next cycle.
REQ-020 SHALL commit the holding register to its channel target in the cycle after acceptance; host_ready returns to 1 in the cycle after the commit.
REQ-021 SHALL write enc_level to the target of enc_chan in the same cycle enc_valid is 1.
REQ-022 SHALL, when an encoder write and a host commit address the same channel in the same cycle, apply the host commit and drop the encoder write; different channels are both applied.
REQ-023 SHALL ignore writes to channel index 3 (a host write is still accepted and released).
REQ-024 SHALL, with fade_en=0, set current to target one cycle after any target change; state stays IDLE and done stays 0.
REQ-025 SHALL implement states IDLE and FADING: IDLE->FADING when fade_en=1 and any current != target; FADING->IDLE when all current == target.
REQ-026 SHALL run a tick counter only in FADING, counting 0..TICK_DIV-1 and wrapping; it is cleared in IDLE, so the first step occurs TICK_DIV cycles after entry.
REQ-027 SHALL, on each tick, move every mismatched current by exactly 1 toward its target, without wrap (no 255->0 or 0->255).
REQ-028 SHALL retarget mid-fade without restarting the tick counter; the next step heads toward the new target.
REQ-029 SHALL, if fade_en falls during FADING, jump all currents to targets the next cycle and return to IDLE without pulsing done.
REQ-030 SHALL pulse done for one cycle in the cycle the FADING->IDLE transition occurs by stepping.

Reset
REQ-031 SHALL, while reset is 1, set all targets and currents to RESET_LEVEL, clear the tick counter, empty the holding register, set state IDLE, and drive busy=0, done=0, host_ready=0.
REQ-032 SHALL drive host_ready=1 in the first cycle after reset deasserts; reset mid-fade or with a pending host write discards all of it.

Structure
REQ-033 SHALL take NUM_CH=3, LEVEL_W=8, the channel index type and the IDLE/FADING state enum from shared package rgb_ctrl_pkg.
REQ-034 SHALL instantiate sub-module rgb_fade_channel three times; each holds target/current and performs step/jump.

Verification (TICK_DIV=4, RESET_LEVEL=0)
REQ-035 SHALL cover: fade_en=1, host writes ch0=3 -> busy rises; level0 reads 1,2,3 at 4-cycle intervals; done pulses once with level0=3.
REQ-036 SHALL cover: host ch1=0x80 and enc ch1=0x10 committing in the same cycle, fade_en=0 -> level1=0x80.
REQ-037 SHALL cover: fade_en=0, enc ch2=0xFF -> level2=0xFF next cycle; busy and done stay 0.
REQ-038 SHALL cover: mid-fade ch0 toward 10 at level 5, retarget to 2 -> subsequent ticks give 4,3,2, then done.
REQ-039 SHALL cover: reset asserted mid-fade with the holding register full -> all levels 0, busy=0, host_ready=0 during reset and 1 the cycle after.
REQ-040 SHALL cover: host write to channel 3 -> accepted (host_ready 0 for one cycle), no level changes.
